// File: rtl/dram_bank_ctrl.sv
// Bitmap DRAM bank: RAS/CAS sequencer with nibble write protect, timed precharge and RAS-only refresh.
// Optional page mode, enabled by defining DRAM_PAGE_MODE_EN, keeps the row open between same-row accesses.
module dram_bank_ctrl #(
    parameter int unsigned BANKS      = 2,
    parameter int unsigned NIBBLES    = 2,
    parameter int unsigned ROW_W      = 8,
    parameter int unsigned COL_W      = 8,
    parameter int unsigned T_RCD      = 2,
    parameter int unsigned T_RP       = 2,
    parameter int unsigned T_RFC      = 3,
    parameter int unsigned REF_PERIOD = 64,
    localparam int unsigned BW        = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int unsigned DW        = 4 * NIBBLES
) (
    input  logic               clk,
    input  logic               RESETn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [BW-1:0]      req_bank,
    input  logic [ROW_W-1:0]   req_row,
    input  logic [COL_W-1:0]   req_col,
    input  logic [DW-1:0]      req_wdata,
    input  logic [NIBBLES-1:0] req_wpn,
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               RASn,
    output logic               CASn,
    output logic               ref_busy
);

    localparam int unsigned AW    = BW + ROW_W + COL_W;
    localparam int unsigned Depth = BANKS << (ROW_W + COL_W);
    localparam int unsigned TW    = 8;
    localparam int unsigned RCW   = $clog2(REF_PERIOD);

    typedef enum logic [2:0] {
        StIdle,
        StRas,
        StCas,
        StPre,
`ifdef DRAM_PAGE_MODE_EN
        StPage,
`endif
        StRefresh
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RCW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [ROW_W-1:0]   ref_row_q, ref_row_d;
    logic               ref_pend_q, ref_pend_d;
    logic               we_q, we_d;
    logic [BW-1:0]      bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [NIBBLES-1:0] wpn_q, wpn_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
`ifdef DRAM_PAGE_MODE_EN
    logic [2:0]         idle_q, idle_d;
    logic               same_row;
`endif

    logic [DW-1:0] mem [Depth];
    logic [AW-1:0] addr;
    logic          in_range;
    logic          ref_tick;
    logic          ref_req;
    logic          accept;
    logic          mem_we;
    logic          ras_n;
    logic          cas_n;

    assign addr     = {bank_q, row_q, col_q};
    assign in_range = 32'(bank_q) < BANKS;
    assign ref_tick = (ref_cnt_q == RCW'(REF_PERIOD - 1));
    // A tick in the current cycle counts as pending so refresh beats a simultaneous request.
    assign ref_req  = ref_pend_q | ref_tick;
`ifdef DRAM_PAGE_MODE_EN
    assign same_row = (req_bank == bank_q) && (req_row == row_q);
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ref_cnt_d   = ref_tick ? '0 : ref_cnt_q + 1'b1;
        ref_row_d   = ref_row_q;
        ref_pend_d  = ref_pend_q | ref_tick;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = 1'b0;
        accept      = 1'b0;
        mem_we      = 1'b0;
        ras_n       = 1'b1;
        cas_n       = 1'b1;
`ifdef DRAM_PAGE_MODE_EN
        idle_d      = idle_q;
`endif
        unique case (state_q)
            StIdle: begin
                req_ready = RESETn && !ref_req;
                if (ref_req) begin
                    state_d    = StRefresh;
                    timer_d    = TW'(T_RFC - 1);
                    ref_row_d  = ref_row_q + 1'b1;
                    ref_pend_d = 1'b0;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = StRas;
                    timer_d = TW'(T_RCD - 1);
                end
            end
            StRas: begin
                ras_n = 1'b0;
                if (timer_q == '0) state_d = StCas;
                else timer_d = timer_q - 1'b1;
            end
            StCas: begin
                ras_n = 1'b0;
                cas_n = 1'b0;
                if (we_q) begin
                    mem_we = in_range;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = in_range ? mem[addr] : '0;
                end
`ifdef DRAM_PAGE_MODE_EN
                state_d = StPage;
                idle_d  = '0;
`else
                state_d = StPre;
                timer_d = TW'(T_RP - 1);
`endif
            end
            StPre: begin
                if (timer_q == '0) state_d = StIdle;
                else timer_d = timer_q - 1'b1;
            end
            StRefresh: begin
                ras_n = 1'b0;
                if (timer_q == '0) begin
                    state_d = StPre;
                    timer_d = TW'(T_RP - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef DRAM_PAGE_MODE_EN
            StPage: begin
                ras_n     = 1'b0;
                req_ready = !ref_req && (!req_valid || same_row);
                if (ref_req || (req_valid && !same_row) || (!req_valid && idle_q == 3'd7)) begin
                    state_d = StPre;
                    timer_d = TW'(T_RP - 1);
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = StCas;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        we_d    = accept ? req_we    : we_q;
        bank_d  = accept ? req_bank  : bank_q;
        row_d   = accept ? req_row   : row_q;
        col_d   = accept ? req_col   : col_q;
        wdata_d = accept ? req_wdata : wdata_q;
        wpn_d   = accept ? req_wpn   : wpn_q;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            ref_cnt_q   <= '0;
            ref_row_q   <= '0;
            ref_pend_q  <= 1'b0;
            we_q        <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            wpn_q       <= '1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DRAM_PAGE_MODE_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_row_q   <= ref_row_d;
            ref_pend_q  <= ref_pend_d;
            we_q        <= we_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            wpn_q       <= wpn_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DRAM_PAGE_MODE_EN
            idle_q      <= idle_d;
`endif
        end
    end

    // Storage is deliberately outside the reset domain: contents survive RESETn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (!wpn_q[i]) mem[addr][4*i +: 4] <= wdata_q[4*i +: 4];
            end
        end
    end

    assign RASn      = ras_n;
    assign CASn      = cas_n;
    assign ref_busy  = (state_q == StRefresh);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Self-checking bench for dram_bank_ctrl (default build): scoreboard of expected read data and
// accept cycles, checked on every response; refresh timing checked against the bench's own count.
module tb_dram_bank_ctrl;

    localparam int unsigned TRcd   = 2;
    localparam int unsigned TRp    = 2;
    localparam int unsigned TRfc   = 3;
    localparam int unsigned RefPer = 64;
    localparam int          Lat    = TRcd + 1;
    localparam int          Gap    = TRcd + 1 + TRp + 1;

    logic       clk = 1'b0;
    logic       RESETn;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [0:0] req_bank;
    logic [7:0] req_row;
    logic [7:0] req_col;
    logic [7:0] req_wdata;
    logic [1:0] req_wpn;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       RASn;
    logic       CASn;
    logic       ref_busy;

    dram_bank_ctrl #(
        .BANKS     (2),
        .NIBBLES   (2),
        .ROW_W     (8),
        .COL_W     (8),
        .T_RCD     (TRcd),
        .T_RP      (TRp),
        .T_RFC     (TRfc),
        .REF_PERIOD(RefPer)
    ) dut (
        .clk      (clk),
        .RESETn   (RESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_bank (req_bank),
        .req_row  (req_row),
        .req_col  (req_col),
        .req_wdata(req_wdata),
        .req_wpn  (req_wpn),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .RASn     (RASn),
        .CASn     (CASn),
        .ref_busy (ref_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  ref_seen = 0;
    int  last_entry = 0;
    int  last_rsp = 0;
    bit  busy_prev = 0;
    bit  ref_since = 0;
    bit  have_last = 0;
    bit  chk_spacing = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // One clock: advance to the falling edge and monitor responses and refresh entries.
    task automatic tick();
        sb_t s;
        @(negedge clk);
        cyc++;
        if (!RESETn) begin
            ref_seen  = 0;
            busy_prev = 0;
            have_last = 0;
        end else begin
            if (ref_busy && !busy_prev) begin
                ref_seen++;
                ref_since  = 1;
                last_entry = cyc;
            end
            busy_prev = ref_busy;
            if (!chk_spacing) have_last = 0;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    s = sb.pop_front();
                    check_eq("rdata", 32'(rsp_rdata), 32'(s.data));
                    check_eq("latency", 32'(cyc - s.acc), 32'(Lat));
                end
                if (chk_spacing && have_last && !ref_since)
                    check_eq("spacing", 32'(cyc - last_rsp), 32'(Gap));
                last_rsp  = cyc;
                have_last = 1;
                ref_since = 0;
            end
        end
    endtask

    // For reads, data is the expected read value.
    task automatic issue(input logic we, input logic bank, input logic [7:0] row,
                         input logic [7:0] col, input logic [7:0] data, input logic [1:0] wpn);
        int n;
        n = 0;
        req_we    = we;
        req_bank  = bank;
        req_row   = row;
        req_col   = col;
        req_wdata = data;
        req_wpn   = wpn;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check_eq("ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            if (!we) sb.push_back('{data, cyc + 1});
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int entry;
        RESETn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        req_wdata = '0;
        req_wpn   = '1;
        repeat (3) tick();
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rasn", 32'(RASn), 32'd1);
        check_eq("rst_casn", 32'(CASn), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_ref_row", 32'(dut.ref_row_q), 32'd0);
        RESETn = 1'b1;
        tick();

        // Reset during RAS of a write leaves the old word in place
        issue(1'b1, 1'b0, 8'h10, 8'h20, 8'h5A, 2'b00);
        issue(1'b0, 1'b0, 8'h10, 8'h20, 8'h5A, 2'b00);
        drain();
        issue(1'b1, 1'b0, 8'h10, 8'h20, 8'hA5, 2'b00);
        check_eq("t1_in_ras", 32'(RASn), 32'd0);
        RESETn = 1'b0;
        #1;
        check_eq("t1_rasn_rst", 32'(RASn), 32'd1);
        check_eq("t1_ready_rst", 32'(req_ready), 32'd0);
        tick();
        RESETn = 1'b1;
        tick();
        issue(1'b0, 1'b0, 8'h10, 8'h20, 8'h5A, 2'b00);
        drain();

        // Nibble write protect and bank isolation
        issue(1'b1, 1'b1, 8'h40, 8'h50, 8'hFF, 2'b00);
        issue(1'b1, 1'b1, 8'h40, 8'h50, 8'h3C, 2'b10);
        issue(1'b0, 1'b1, 8'h40, 8'h50, 8'hFC, 2'b00);
        issue(1'b1, 1'b0, 8'h33, 8'h44, 8'h11, 2'b00);
        issue(1'b1, 1'b1, 8'h33, 8'h44, 8'h22, 2'b00);
        issue(1'b0, 1'b0, 8'h33, 8'h44, 8'h11, 2'b00);
        issue(1'b0, 1'b1, 8'h33, 8'h44, 8'h22, 2'b00);
        issue(1'b1, 1'b0, 8'h33, 8'h44, 8'h00, 2'b11);
        issue(1'b1, 1'b1, 8'h33, 8'h44, 8'hE7, 2'b01);
        issue(1'b0, 1'b0, 8'h33, 8'h44, 8'h11, 2'b00);
        issue(1'b0, 1'b1, 8'h33, 8'h44, 8'hE2, 2'b00);
        drain();

        // Back-to-back reads at the minimum issue interval
        chk_spacing = 1;
        for (int i = 0; i < 16; i++) begin
            logic b;
            b = i[0];
            issue(1'b0, b, 8'h33, 8'h44, b ? 8'hE2 : 8'h11, 2'b00);
        end
        drain();
        chk_spacing = 0;

        // Idle until the refresh row reaches 0xFF, then collide a request with the next tick
        n = 0;
        while (ref_seen < 255 && n < 20000) begin
            tick();
            n++;
        end
        check_eq("t4_ref_count", 32'(ref_seen), 32'd255);
        check_eq("t4_ref_row_ff", 32'(dut.ref_row_q), 32'(ref_seen[7:0]));
        n = 0;
        while (cyc < last_entry + RefPer - 1 && n < 100) begin
            tick();
            n++;
        end
        req_we    = 1'b0;
        req_bank  = 1'b1;
        req_row   = 8'h33;
        req_col   = 8'h44;
        req_wpn   = 2'b00;
        req_valid = 1'b1;
        #1;
        check_eq("t4_ready_at_tick", 32'(req_ready), 32'd0);
        check_eq("t4_busy_before", 32'(ref_busy), 32'd0);
        tick();
        entry = cyc;
        check_eq("t4_busy_entry", 32'(ref_busy), 32'd1);
        check_eq("t4_ref_row_wrap", 32'(dut.ref_row_q), 32'(ref_seen[7:0]));
        check_eq("t4_ref_row_zero", 32'(dut.ref_row_q), 32'd0);
        check_eq("t4_rasn", 32'(RASn), 32'd0);
        check_eq("t4_casn", 32'(CASn), 32'd1);
        n = 0;
        while (ref_busy && n < 20) begin
            n++;
            tick();
        end
        check_eq("t4_busy_cycles", 32'(n), 32'(TRfc));
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("t4_accept_delay", 32'(cyc - entry), 32'(TRfc + TRp));
        if (req_ready) begin
            sb.push_back('{8'hE2, cyc + 1});
            tick();
        end
        req_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
